branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 18 +
 rtl/sat_counter.sv | 41 ++++
 rtl/branch_predictor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared OTTER branch predictor types and default parameter constants.
package branch_predictor_pkg;

  localparam int unsigned EntriesDefault = 64;
  localparam int unsigned TagWDefault    = 8;
  localparam int unsigned CntWDefault    = 2;

  // Tag field is sized for the widest legal tag; narrower tags are zero-extended.
  localparam int unsigned MaxTagW = 30;

  typedef struct packed {
    logic               valid;
    logic [MaxTagW-1:0] tag;
    logic [31:0]        target;
    logic               jump;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Per-entry saturating up/down direction counter.
// Reset loads weakly not-taken; allocation loads weakly taken.
module sat_counter #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o
);

  localparam logic [CntW-1:0] CntMax       = {CntW{1'b1}};
  localparam logic [CntW-1:0] WeakTaken    = CntW'(1) << (CntW - 1);
  localparam logic [CntW-1:0] WeakNotTaken = WeakTaken - CntW'(1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (alloc_i) begin
      cnt_d = WeakTaken;
    end else if (inc_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= WeakNotTaken;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Zero-latency lookup from IF; training and mispredict detection from EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = EntriesDefault,
  parameter int unsigned TAG_W   = TagWDefault,
  parameter int unsigned CNT_W   = CntWDefault
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  output logic        PRED_TAKEN,
  output logic [31:0] PRED_TARGET,
  input  logic        UPD_VALID,
  input  logic [31:0] UPD_PC,
  input  logic        UPD_IS_BR,
  input  logic        UPD_IS_JMP,
  input  logic        UPD_TAKEN,
  input  logic [31:0] UPD_TARGET,
  input  logic        UPD_PRED_TAKEN,
  input  logic [31:0] UPD_PRED_TARGET,
  output logic        MISPREDICT,
  output logic [31:0] UPD_COUNT,
  output logic [31:0] MISPRED_COUNT
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  bp_entry_t        entries_q [ENTRIES];
  logic [CNT_W-1:0] cnt       [ENTRIES];

  logic [IdxW-1:0]    if_idx, upd_idx;
  logic [MaxTagW-1:0] if_tag, upd_tag;

  assign if_idx  = IF_PC[IdxW+1:2];
  assign if_tag  = MaxTagW'(IF_PC[IdxW+TAG_W+1:IdxW+2]);
  assign upd_idx = UPD_PC[IdxW+1:2];
  assign upd_tag = MaxTagW'(UPD_PC[IdxW+TAG_W+1:IdxW+2]);

  logic unused_upd_pc;
  assign unused_upd_pc = ^UPD_PC;

  // Lookup reads the registered table, so a same-cycle update is never bypassed.
  bp_entry_t if_entry;
  logic      if_hit;

  assign if_entry    = entries_q[if_idx];
  assign if_hit      = !RESET && if_entry.valid && (if_entry.tag == if_tag);
  assign PRED_TAKEN  = if_hit && (if_entry.jump || cnt[if_idx][CNT_W-1]);
  assign PRED_TARGET = if_hit ? if_entry.target : IF_PC + 32'd4;

  // Non-control instructions resolve as not-taken.
  logic upd_ctrl, upd_actual_taken;
  assign upd_ctrl         = UPD_IS_BR || UPD_IS_JMP;
  assign upd_actual_taken = upd_ctrl && UPD_TAKEN;
  assign MISPREDICT = UPD_VALID &&
                      ((UPD_PRED_TAKEN != upd_actual_taken) ||
                       (upd_actual_taken && (UPD_PRED_TARGET != UPD_TARGET)));

  bp_entry_t upd_entry, tbl_d;
  logic      upd_hit, tbl_we, cnt_alloc, cnt_inc, cnt_dec;

  assign upd_entry = entries_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  always_comb begin
    tbl_d     = upd_entry;
    tbl_we    = 1'b0;
    cnt_alloc = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    if (UPD_VALID) begin
      if (!upd_ctrl) begin
        // Aliased entry made a non-branch look taken: drop it.
        if (UPD_PRED_TAKEN && upd_hit) begin
          tbl_we      = 1'b1;
          tbl_d.valid = 1'b0;
        end
      end else if (upd_hit) begin
        tbl_we     = 1'b1;
        tbl_d.jump = UPD_IS_JMP;
        if (UPD_TAKEN) begin
          tbl_d.target = UPD_TARGET;
        end
        cnt_inc = UPD_TAKEN;
        cnt_dec = !UPD_TAKEN;
      end else if (UPD_TAKEN) begin
        tbl_we    = 1'b1;
        tbl_d     = '{valid: 1'b1, tag: upd_tag, target: UPD_TARGET, jump: UPD_IS_JMP};
        cnt_alloc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_q[i] <= '0;
      end
    end else if (tbl_we) begin
      entries_q[upd_idx] <= tbl_d;
    end
  end

  for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_cnt
    logic sel;
    assign sel = (upd_idx == IdxW'(g));

    sat_counter #(
      .CntW(CNT_W)
    ) u_cnt (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .alloc_i(sel && cnt_alloc),
      .inc_i  (sel && cnt_inc),
      .dec_i  (sel && cnt_dec),
      .cnt_o  (cnt[g])
    );
  end

  logic [31:0] upd_count_d, upd_count_q, mispred_count_d, mispred_count_q;

  always_comb begin
    upd_count_d     = upd_count_q + (UPD_VALID ? 32'd1 : 32'd0);
    mispred_count_d = mispred_count_q + (MISPREDICT ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      upd_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      upd_count_q     <= upd_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign UPD_COUNT     = upd_count_q;
  assign MISPRED_COUNT = mispred_count_q;

endmodule
